// File: rtl/cost_sched_pkg.sv
// Shared types and widths for the cost batch scheduler and its accumulator.
package cost_sched_pkg;

  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned CONF_W     = 4;
  localparam int unsigned COST_W     = 8;

  typedef logic [0:NUM_DIGITS-1] label_t;
  typedef logic [0:NUM_DIGITS-1][CONF_W-1:0] weights_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_ACCUM,
    ST_DONE
  } cost_sched_state_t;

endpackage

// File: rtl/cost_accumulator.sv
// Saturating batch-cost sum, sample counter, sticky saturation flag and mean
// (sum >> LOG2_BATCH clipped to 8 bits, captured when the batch closes).
module cost_accumulator
  import cost_sched_pkg::*;
#(
  parameter int unsigned BATCH_SIZE = 16,
  parameter int unsigned LOG2_BATCH = 4,
  parameter int unsigned ACC_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic              latch_mean,
  input  logic [COST_W-1:0] cost,
  output logic [ACC_W-1:0]  sum,
  output logic [COST_W-1:0] mean,
  output logic              saturated,
  output logic              last_c
);

  localparam int unsigned CNT_W = LOG2_BATCH;
  localparam int unsigned EXT_W = ACC_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [COST_W-1:0] mean_q, mean_d;
  logic              sat_q, sat_d;
  logic [EXT_W-1:0]  sum_ext;
  logic [ACC_W-1:0]  shifted;

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    sat_d   = sat_q;
    mean_d  = mean_q;
    sum_ext = EXT_W'(sum_q) + EXT_W'(cost);
    if (clear) begin
      sum_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
      mean_d  = '0;
    end else if (add) begin
      count_d = count_q + CNT_W'(1);
      if (sum_ext[ACC_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_W-1:0];
      end
    end
    // Mean uses the post-add sum so it is valid alongside batch_done.
    shifted = sum_d >> LOG2_BATCH;
    if (latch_mean) begin
      mean_d = (shifted > ACC_W'(255)) ? '1 : COST_W'(shifted);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      mean_q  <= '0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      mean_q  <= mean_d;
    end
  end

  assign sum       = sum_q;
  assign mean      = mean_q;
  assign saturated = sat_q;
  assign last_c    = (count_q == CNT_W'(BATCH_SIZE - 1));

endmodule

// File: rtl/cost_batch_scheduler.sv
// Sequences the cost calculator over one training batch and reports sum/mean.
// Optional per-sample wait watchdog enabled by defining COST_WATCHDOG_EN.
module cost_batch_scheduler
  import cost_sched_pkg::*;
#(
  parameter int unsigned BATCH_SIZE = 16,
  parameter int unsigned LOG2_BATCH = 4,
  parameter int unsigned ACC_W      = 16
`ifdef COST_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_LIMIT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  label_t            sample_label,
  input  weights_t          sample_weights,
  output logic              cost_en,
  output label_t            expected_label,
  output weights_t          digit_weights,
  input  logic              calculation_complete,
  input  logic [COST_W-1:0] cost_output,
  output logic              batch_busy,
  output logic              batch_done,
  output logic [ACC_W-1:0]  batch_cost_sum,
  output logic [COST_W-1:0] batch_cost_mean,
  output logic              batch_saturated,
  output logic              batch_error
);

  cost_sched_state_t state_q, state_d;
  label_t            label_q, label_d;
  weights_t          weights_q, weights_d;
  logic              sample_ready_q, sample_ready_d;
  logic              cost_en_q, cost_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              acc_clear, acc_add, acc_latch_mean, acc_last_c;
`ifdef COST_WATCHDOG_EN
  logic [7:0]        wdog_q, wdog_d;
  logic              error_q, error_d;
`endif

  always_comb begin
    state_d   = state_q;
    label_d   = label_q;
    weights_d = weights_q;
    cost_en_d = 1'b0;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
`ifdef COST_WATCHDOG_EN
    wdog_d    = '0;
    error_d   = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          state_d   = ST_FETCH;
`ifdef COST_WATCHDOG_EN
          error_d   = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (sample_valid && sample_ready_q) begin
          label_d   = sample_label;
          weights_d = sample_weights;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (calculation_complete) begin
          cost_en_d = 1'b1;
          state_d   = ST_WAIT_BUSY;
        end
      end
      // Wait for the done level to drop first so a stale done is not taken.
      ST_WAIT_BUSY: if (!calculation_complete) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (calculation_complete) state_d = ST_ACCUM;
      ST_ACCUM: begin
        acc_add = 1'b1;
        state_d = acc_last_c ? ST_DONE : ST_FETCH;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef COST_WATCHDOG_EN
    if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
      if (wdog_q == 8'(WDOG_LIMIT)) begin
        state_d = ST_DONE;
        error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 8'd1;
      end
    end
`endif
    sample_ready_d = (state_d == ST_FETCH);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
  end

  assign acc_latch_mean = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      label_q        <= '0;
      weights_q      <= '0;
      sample_ready_q <= 1'b0;
      cost_en_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef COST_WATCHDOG_EN
      wdog_q         <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      label_q        <= label_d;
      weights_q      <= weights_d;
      sample_ready_q <= sample_ready_d;
      cost_en_q      <= cost_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef COST_WATCHDOG_EN
      wdog_q         <= wdog_d;
      error_q        <= error_d;
`endif
    end
  end

  cost_accumulator #(
    .BATCH_SIZE (BATCH_SIZE),
    .LOG2_BATCH (LOG2_BATCH),
    .ACC_W      (ACC_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .add        (acc_add),
    .latch_mean (acc_latch_mean),
    .cost       (cost_output),
    .sum        (batch_cost_sum),
    .mean       (batch_cost_mean),
    .saturated  (batch_saturated),
    .last_c     (acc_last_c)
  );

  assign sample_ready   = sample_ready_q;
  assign cost_en        = cost_en_q;
  assign expected_label = label_q;
  assign digit_weights  = weights_q;
  assign batch_busy     = busy_q;
  assign batch_done     = done_q;
`ifdef COST_WATCHDOG_EN
  assign batch_error    = error_q;
`else
  assign batch_error    = 1'b0;
`endif

endmodule

// File: tb/tb_cost_batch_scheduler.sv
// Directed bench for cost_batch_scheduler: default instance (A) and an
// ACC_W=8, BATCH_SIZE=2 instance (B) sharing one calculator stub.
module tb_cost_batch_scheduler;
  import cost_sched_pkg::*;

  localparam int unsigned LAT = 6;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, sample_valid;
  label_t   sample_label;
  weights_t sample_weights;
  logic calc_cc;
  logic [7:0] calc_cost;

  logic ready_a, cen_a, busy_a, done_a, sat_a, err_a;
  label_t lbl_a;  weights_t wts_a;
  logic [15:0] sum_a;  logic [7:0] mean_a;
  logic ready_b, cen_b, busy_b, done_b, sat_b, err_b;
  label_t lbl_b;  weights_t wts_b;
  logic [7:0] sum_b;  logic [7:0] mean_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cen_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [7:0] stub_cost = 8'd0;
  logic stub_stuck = 1'b0;
  int stub_cnt;

  always #5 clk = ~clk;

  cost_batch_scheduler
`ifdef COST_WATCHDOG_EN
    #(.WDOG_LIMIT(10))
`endif
  dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sample_valid(sample_valid),
    .sample_ready(ready_a), .sample_label(sample_label), .sample_weights(sample_weights),
    .cost_en(cen_a), .expected_label(lbl_a), .digit_weights(wts_a),
    .calculation_complete(calc_cc), .cost_output(calc_cost),
    .batch_busy(busy_a), .batch_done(done_a), .batch_cost_sum(sum_a),
    .batch_cost_mean(mean_a), .batch_saturated(sat_a), .batch_error(err_a));

  cost_batch_scheduler #(.BATCH_SIZE(2), .LOG2_BATCH(1), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sample_valid(sample_valid),
    .sample_ready(ready_b), .sample_label(sample_label), .sample_weights(sample_weights),
    .cost_en(cen_b), .expected_label(lbl_b), .digit_weights(wts_b),
    .calculation_complete(calc_cc), .cost_output(calc_cost),
    .batch_busy(busy_b), .batch_done(done_b), .batch_cost_sum(sum_b),
    .batch_cost_mean(mean_b), .batch_saturated(sat_b), .batch_error(err_b));

  // Calculator stub: drops done for LAT cycles after cost_en, then presents stub_cost.
  always @(posedge clk) begin
    if (rst) begin
      calc_cc   <= 1'b1;
      calc_cost <= 8'd0;
      stub_cnt  <= 0;
    end else if ((cen_a || cen_b) && !stub_stuck) begin
      calc_cc  <= 1'b0;
      stub_cnt <= LAT;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        calc_cc   <= 1'b1;
        calc_cost <= stub_cost;
      end
    end
  end

  always @(posedge clk) begin
    if (cen_a)  cen_cnt_a  <= cen_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  typedef struct {
    int         sel;
    int         n;
    label_t     label;
    weights_t   w;
    logic [7:0] cost;
    logic [15:0] sum;
    logic [7:0] mean;
    logic       sat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic label_t onehot(input int k);
    label_t l;
    l = '0;
    l[k] = 1'b1;
    return l;
  endfunction

  function automatic weights_t wfill(input logic [3:0] v);
    weights_t w;
    for (int i = 0; i < 10; i++) w[i] = v;
    return w;
  endfunction

  task automatic pulse_start(input int sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input int sel, input label_t l, input weights_t w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((sel == 0 && ready_a) || (sel == 1 && ready_b)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    sample_label   = l;
    sample_weights = w;
    sample_valid   = 1'b1;
    @(negedge clk);
    sample_valid   = 1'b0;
    check("held_label",   (sel == 0) ? 64'(lbl_a) : 64'(lbl_b), 64'(l));
    check("held_weights", (sel == 0) ? 64'(wts_a) : 64'(wts_b), 64'(w));
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (!((sel == 0) ? done_a : done_b) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc, c0, d0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sample_valid = 1'b0;
    sample_label = '0; sample_weights = '0;

    vecs[0] = '{0, 16, onehot(0), wfill(4'd0), 8'd16, 16'd256, 8'd16, 1'b0};
    vecs[1] = '{0, 16, onehot(3), wfill(4'd0), 8'd0, 16'd0, 8'd0, 1'b0};
    vecs[1].w[3] = 4'd8;
    vecs[2] = '{0, 16, onehot(9), wfill(4'd5), 8'd200, 16'd3200, 8'd200, 1'b0};
    vecs[3] = '{0, 16, onehot(5), wfill(4'd10), 8'd255, 16'd4080, 8'd255, 1'b0};
    vecs[4] = '{1, 2, onehot(0), wfill(4'd15), 8'd228, 16'd255, 8'd127, 1'b1};
    vecs[5] = '{1, 2, onehot(7), wfill(4'd3), 8'd100, 16'd200, 8'd100, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_a), 64'd0);
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_sum",   64'(sum_a),   64'd0);
    check("rst_mean",  64'(mean_a),  64'd0);
    check("rst_label", 64'(lbl_a),   64'd0);

    for (int v = 0; v < 6; v++) begin
      stub_cost = vecs[v].cost;
      c0 = cen_cnt_a;
      d0 = (vecs[v].sel == 0) ? done_cnt_a : done_cnt_b;
      pulse_start(vecs[v].sel);
      for (int s = 0; s < vecs[v].n; s++) feed(vecs[v].sel, vecs[v].label, vecs[v].w);
      wait_done(vecs[v].sel, cyc);
      if (vecs[v].sel == 0) begin
        check("sum",  64'(sum_a),  64'(vecs[v].sum));
        check("mean", 64'(mean_a), 64'(vecs[v].mean));
        check("sat",  64'(sat_a),  64'(vecs[v].sat));
        check("err",  64'(err_a),  64'd0);
        check("cost_en_count", 64'(cen_cnt_a - c0), 64'(vecs[v].n));
      end else begin
        check("sum_b",  64'(sum_b),  64'(vecs[v].sum));
        check("mean_b", 64'(mean_b), 64'(vecs[v].mean));
        check("sat_b",  64'(sat_b),  64'(vecs[v].sat));
      end
      @(negedge clk);
      check("idle_busy", (vecs[v].sel == 0) ? 64'(busy_a) : 64'(busy_b), 64'd0);
      check("held_sum",  (vecs[v].sel == 0) ? 64'(sum_a) : 64'(sum_b), 64'(vecs[v].sum));
      check("done_pulses", (vecs[v].sel == 0) ? 64'(done_cnt_a - d0) : 64'(done_cnt_b - d0), 64'd1);
    end

    // Stalled FETCH with a stray start mid-batch.
    stub_cost = 8'd10;
    pulse_start(0);
    for (int s = 0; s < 3; s++) feed(0, onehot(2), wfill(4'd7));
    wait (ready_a == 1'b1 || busy_a == 1'b0);
    @(negedge clk);
    c0 = cen_cnt_a;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    check("stall_cost_en", 64'(cen_cnt_a - c0), 64'd0);
    check("stall_ready",   64'(ready_a), 64'd1);
    check("stall_sum",     64'(sum_a),   64'd30);
    for (int s = 3; s < 16; s++) feed(0, onehot(2), wfill(4'd7));
    wait_done(0, cyc);
    check("stall_final_sum",  64'(sum_a),  64'd160);
    check("stall_final_mean", 64'(mean_a), 64'd10);

    // Reset while waiting on the 5th sample's calculation.
    @(negedge clk);
    stub_cost = 8'd20;
    pulse_start(0);
    for (int s = 0; s < 5; s++) feed(0, onehot(1), wfill(4'd2));
    cyc = 0;
    while (calc_cc && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_calc_started", 64'(calc_cc), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",    64'(busy_a),  64'd0);
    check("midrst_cost_en", 64'(cen_a),   64'd0);
    check("midrst_ready",   64'(ready_a), 64'd0);
    check("midrst_sum",     64'(sum_a),   64'd0);
    check("midrst_label",   64'(lbl_a),   64'd0);
    stub_cost = 8'd7;
    pulse_start(0);
    for (int s = 0; s < 16; s++) feed(0, onehot(4), wfill(4'd1));
    wait_done(0, cyc);
    check("post_rst_sum",  64'(sum_a),  64'd112);
    check("post_rst_mean", 64'(mean_a), 64'd7);
    @(negedge clk);

`ifdef COST_WATCHDOG_EN
    stub_stuck = 1'b1;
    pulse_start(0);
    feed(0, onehot(6), wfill(4'd9));
    wait_done(0, cyc);
    check("wdog_cycles", 64'(cyc), 64'd12);
    check("wdog_error",  64'(err_a), 64'd1);
    check("wdog_sum",    64'(sum_a), 64'd0);
    @(negedge clk);
    pulse_start(0);
    check("wdog_error_cleared", 64'(err_a), 64'd0);
    rst = 1'b1;
    stub_stuck = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`else
    check("error_tied", 64'(err_a), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cost_batch_scheduler.md
Name: cost_batch_scheduler

Overview:
Controller that sequences the cost calculator over a training batch. It accepts one sample at a time (expected label plus ten digit confidences) over a valid/ready handshake. For each sample it drives the cost-enable pulse, waits for the calculator to finish, then folds the 8-bit per-sample cost into a saturating batch sum. At the end of the batch it reports the sum and the mean cost to the training control logic.

Parameters:
BATCH_SIZE, 16, samples per batch; must be a power of two, minimum 2.
LOG2_BATCH, 4, log2(BATCH_SIZE); used for the mean shift.
ACC_W, 16, batch-sum width; the sum saturates at 2^ACC_W-1.
WDOG_LIMIT, 255, maximum wait cycles per sample (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE
sample_valid  in  1  sample presented
sample_ready  out  1  scheduler accepts a sample; high only in FETCH
sample_label  in  [0:9]  one-hot expected label
sample_weights  in  [0:9][3:0]  digit confidences
cost_en  out  1  pulse to the calculator
expected_label  out  [0:9]  held copy of the accepted label
digit_weights  out  [0:9][3:0]  held copy of the accepted weights
calculation_complete  in  1  calculator idle/done; high when idle
cost_output  in  8  per-sample cost from the calculator
batch_busy  out  1  high in every state except IDLE
batch_done  out  1  one-cycle pulse, in DONE
batch_cost_sum  out  ACC_W  saturating sum; held until the next start
batch_cost_mean  out  8  min(sum>>LOG2_BATCH, 255); held until the next start
batch_saturated  out  1  sticky; set if any add clipped; cleared by start
batch_error  out  1  watchdog fired (optional feature; otherwise tied 0)

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. Hold registers, sample counter and sum all cleared.
- States: IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE, ACCUM, DONE.
- IDLE: on start, clear sum, counter and batch_saturated, then go to FETCH. Sum and mean keep their previous values until this start.
- FETCH: sample_ready=1. A transfer occurs when sample_valid and sample_ready are both high. On transfer, latch sample_label and sample_weights into expected_label and digit_weights, then go to ISSUE. Data is presented one cycle after acceptance.
- ISSUE: if calculation_complete=1, assert cost_en for exactly one cycle and go to WAIT_BUSY. Otherwise stay in ISSUE with cost_en=0.
- Held label and weights are stable from ISSUE through ACCUM.
- WAIT_BUSY: wait for calculation_complete=0, then go to WAIT_DONE. This guards against sampling the stale done level.
- WAIT_DONE: wait for calculation_complete=1, then go to ACCUM.
- ACCUM: sum <= sat(sum + cost_output) and counter++.
  - Saturation: if the true sum exceeds 2^ACC_W-1, the result is all-ones and batch_saturated is set.
  - If counter reaches BATCH_SIZE, go to DONE; otherwise go to FETCH.
- DONE: batch_done=1 for one cycle. Mean is computed combinationally from the final sum and registered. Return to IDLE.
- batch_busy is 0 in IDLE only. start pulses outside IDLE are ignored, with no effect on counter or sum.
- Mid-operation rst: immediate return to IDLE, cost_en deasserted in the same cycle, partial sum discarded. The calculator is reset separately.
- Per-sample latency: about 52 cycles of calculator time, plus 4 cycles of scheduler overhead (ISSUE, WAIT_BUSY entry, ACCUM, FETCH).

Optional Feature:
COST_WATCHDOG_EN
- Defined: an 8-bit wait counter runs during WAIT_BUSY and WAIT_DONE and resets on entry to ISSUE.
  - On reaching WDOG_LIMIT: set batch_error (sticky until start) and go to DONE with the partial sum.
  - batch_done still pulses.
- Undefined: no counter; batch_error tied to 0; the scheduler waits indefinitely.

Decomposition:
Package cost_sched_pkg contains:
- the state enum cost_sched_state_t;
- NUM_DIGITS=10, CONF_W=4, COST_W=8;
- the type label_t = logic [0:9] and the type weights_t = logic [0:9][3:0].

Sub-module cost_accumulator (saturating ACC_W adder, sample counter, sticky flag, mean shift) is instantiated once.

Test Plan:
- Label bit index 0 set, weights all 0, 16 samples, real calculator attached. Expected: each cost 16; batch_cost_sum=256, mean=16, batch_saturated=0; batch_done pulses once.
- Label bit 3 set, weight[3]=8, all other weights 0, 16 samples. Expected: per-sample cost 0, sum=0, mean=0.
- ACC_W=8 override; label bit 0 set, all weights 15 (cost 228 each), 2 samples. Expected: sum=255, batch_saturated=1, mean=127.
- sample_valid held low for 20 cycles in FETCH, plus a start pulse mid-batch. Expected: no cost_en; counter unchanged; start ignored; batch completes normally.
- rst asserted in WAIT_DONE of sample 5. Expected: next cycle state IDLE, all outputs 0; a new start then runs a clean 16-sample batch.
- COST_WATCHDOG_EN, WDOG_LIMIT=10, calculator stub that never drops calculation_complete. Expected: batch_error=1 and batch_done after about 11 cycles in WAIT_BUSY, sum=0.
